// File: rtl/tx_seq_pkg.sv
// Shared types and helpers for the TX filter input sequencer.
// Imported by the sequencer top and its strobe generator.
package tx_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic {
        STREAM  = 1'b0,
        IMPULSE = 1'b1
    } mode_t;

    localparam int SAMP_W = 18;
    localparam int UF_W   = 16;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tx_samp_stb_gen.sv
// Sample-rate strobe and symbol phase generator for the TX filter sequencer.
// div_cnt divides the clock by CLK_DIV; phase counts samples within a symbol.
module tx_samp_stb_gen
    import tx_seq_pkg::*;
#(
    parameter int OSR     = 4,
    parameter int CLK_DIV = 1,
    localparam int PH_W   = clog2_min1(OSR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    output logic            samp_stb,
    output logic [PH_W-1:0] phase
);

    localparam int              DV_W    = clog2_min1(CLK_DIV);
    localparam logic [DV_W-1:0] DV_LAST = DV_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

    logic [DV_W-1:0] div_cnt;

    assign samp_stb = en && (div_cnt == DV_LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DV_LAST) ? '0 : div_cnt + DV_W'(1);
            if (samp_stb) begin
                phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/tx_filt_seq.sv
// Sequencer feeding the TX pulse-shaping filter: zero-stuffed upsampling of
// handshaked symbols, a built-in impulse source, and a zero flush after stop.
module tx_filt_seq
    import tx_seq_pkg::*;
#(
    parameter int                      WIDTH       = SAMP_W,
    parameter int                      OSR         = 4,
    parameter int                      CLK_DIV     = 1,
    parameter int                      FLUSH_LEN   = 32,
    parameter logic signed [WIDTH-1:0] IMPULSE_VAL = 18'sd131071
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] sym_data,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic                    x_valid,
    output logic                    busy,
    output logic                    done,
    output logic [UF_W-1:0]         underflow_cnt,
    output state_t                  state
);

    localparam int              PH_W   = clog2_min1(OSR);
    localparam int              FL_W   = clog2_min1(FLUSH_LEN + 1);
    localparam logic [FL_W-1:0] FL_LEN = FL_W'(FLUSH_LEN);
    localparam logic [FL_W-1:0] FL_ONE = FL_W'(1);
    localparam logic [UF_W-1:0] UF_MAX = '1;

    state_t          state_nxt;
    mode_t           run_mode;
    logic            imp_first;
    logic [FL_W-1:0] flush_cnt;
    logic            samp_stb;
    logic [PH_W-1:0] phase;

    logic take_start;
    logic run_emit;
    logic flush_stb;
    logic flush_last;
    logic stream_slot;
    logic emit;

    tx_samp_stb_gen #(
        .OSR     (OSR),
        .CLK_DIV (CLK_DIV)
    ) u_stb (
        .clk      (clk),
        .reset    (reset),
        .en       (state != IDLE),
        .clr      (state == IDLE),
        .samp_stb (samp_stb),
        .phase    (phase)
    );

    // A stop in RUN swallows the strobe it coincides with: no sample, no symbol.
    assign take_start  = (state == IDLE) && start;
    assign run_emit    = (state == RUN) && samp_stb && !stop;
    assign flush_stb   = (state == FLUSH) && samp_stb;
    assign flush_last  = flush_stb && (flush_cnt == FL_ONE);
    assign stream_slot = run_emit && (run_mode == STREAM) && (phase == '0);
    assign emit        = run_emit || flush_stb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (stop) state_nxt = FLUSH;
            FLUSH:   if (flush_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sym_ready never looks at sym_valid, so the source may wait on it freely.
    always_comb begin
        sym_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            RUN: begin
                busy      = 1'b1;
                sym_ready = stream_slot;
            end
            FLUSH:   busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_mode      <= STREAM;
            imp_first     <= 1'b0;
            flush_cnt     <= '0;
            x_out         <= '0;
            x_valid       <= 1'b0;
            done          <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            x_valid <= emit;
            done    <= flush_last;

            if (take_start) begin
                run_mode  <= mode_t'(mode);
                imp_first <= 1'b1;
            end else if (run_emit || state != RUN) begin
                imp_first <= 1'b0;
            end

            if ((state == RUN) && stop) begin
                flush_cnt <= FL_LEN;
            end else if (flush_stb) begin
                flush_cnt <= flush_cnt - FL_W'(1);
            end

            if (take_start) begin
                underflow_cnt <= '0;
            end else if (stream_slot && !sym_valid && underflow_cnt != UF_MAX) begin
                underflow_cnt <= underflow_cnt + UF_W'(1);
            end

            // x_out only moves together with x_valid, except the return to 0 in IDLE.
            if (run_emit) begin
                if (run_mode == IMPULSE) begin
                    x_out <= imp_first ? IMPULSE_VAL : '0;
                end else if (phase == '0 && sym_valid) begin
                    x_out <= sym_data;
                end else begin
                    x_out <= '0;
                end
            end else if (flush_stb || state == IDLE) begin
                x_out <= '0;
            end
        end
    end

endmodule

// File: doc/tx_filt_seq.md
Name: tx_filt_seq

Overview:
- Sequences the transmit pulse-shaping filter (TX_filt) datapath.
- Accepts 1s17 symbols from an upstream source over a valid/ready handshake and upsamples them by OSR through zero-stuffing.
- Drives the filter input at the sample rate and, on stop, flushes the filter taps with zeros.
- Also provides a built-in impulse mode that produces the filter impulse response without an external stimulus.

Parameters:
- WIDTH, 18: sample width, signed 1s17.
- OSR, 4: samples per symbol; legal range 2..16.
- CLK_DIV, 1: clocks per sample; legal range 1..256.
- FLUSH_LEN, 32: zero samples emitted after stop; must be at least the filter length.
- IMPULSE_VAL, 18'sd131071: sample value emitted in impulse mode (+max 1s17).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: single-cycle pulse that begins a run.
- stop, in, 1: single-cycle pulse that ends a run and starts the flush.
- mode, in, 1: 0 = stream, 1 = impulse; sampled only on the accepted start.
- sym_data, in, WIDTH: signed symbol from the upstream source.
- sym_valid, in, 1: sym_data is valid.
- sym_ready, out, 1: sequencer accepts a symbol this cycle.
- x_out, out, WIDTH: signed sample to the filter x_in.
- x_valid, out, 1: one-cycle strobe marking a new x_out.
- busy, out, 1: high in RUN and FLUSH.
- done, out, 1: one-cycle pulse when FLUSH completes.
- underflow_cnt, out, 16: count of symbol slots missed in stream mode; saturates.

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values: state IDLE, all counters 0, x_out 0, x_valid 0, sym_ready 0, busy 0, done 0, underflow_cnt 0. Reset asserted mid-run aborts immediately; done is not pulsed.
- States: IDLE, RUN, FLUSH.
  - IDLE to RUN on start. div_cnt and phase are cleared, and mode is latched into run_mode.
  - RUN to FLUSH on stop. The flush counter is loaded with FLUSH_LEN.
  - FLUSH to IDLE when the flush counter reaches 0 on a sample strobe. done is pulsed in the same cycle as the transition.
- Ignored and simultaneous events:
  - start outside IDLE is ignored.
  - stop outside RUN is ignored.
  - start and stop in the same cycle in IDLE: start wins, stop is ignored.
  - A stop in RUN takes effect in that cycle; no sample is emitted by the strobe that coincides with it.
- Strobe generation (in RUN and FLUSH only):
  - div_cnt counts 0..CLK_DIV-1 and wraps; samp_stb = (div_cnt == CLK_DIV-1).
  - phase counts 0..OSR-1, advancing on samp_stb.
  - In IDLE, both counters are held at 0.
- Stream mode, RUN, on samp_stb:
  - If phase == 0, sym_ready = 1 combinationally. If sym_valid, x_out <= sym_data.
  - If phase == 0 and sym_valid is low, x_out <= 0 and underflow_cnt increments, saturating at 16'hFFFF.
  - If phase != 0, x_out <= 0.
  - sym_ready is 0 in all other cycles. A transfer occurs only when sym_valid and sym_ready are both high.
- Impulse mode, RUN, on samp_stb:
  - The first sample after start is IMPULSE_VAL; every later sample is 0.
  - sym_ready stays 0 and underflow_cnt is not incremented.
- FLUSH, on samp_stb: x_out <= 0 and the flush counter decrements.
- x_valid:
  - Equals samp_stb registered, so it is high in the same cycle the new x_out appears. Latency from samp_stb to x_out is 1 clock.
  - With CLK_DIV = 1, x_valid is high every cycle in RUN and FLUSH.
- x_out holds its last value whenever x_valid is low. It returns to 0 on entry to IDLE.
- underflow_cnt clears only on reset or on an accepted start.

Decomposition:
- Package tx_seq_pkg:
  - state_t enum {IDLE, RUN, FLUSH}.
  - mode_t enum {STREAM, IMPULSE}.
  - Constants SAMP_W = 18 and UF_W = 16.
  - Function clog2_min1 for counter widths.
- Sub-module tx_samp_stb_gen:
  - Contains div_cnt and phase.
  - Inputs: en, clr. Outputs: samp_stb, phase.
- The FSM, data mux and underflow counter live in the top module.

Test Plan:
- Reset check: hold reset for 21 cycles with start pulsed during reset. All outputs stay 0 and the state stays IDLE after release.
- Stream, OSR = 4, CLK_DIV = 1: source always valid with symbols 1000, -2000, 3000. Expect x_out = 1000, 0, 0, 0, -2000, 0, 0, 0, 3000, ... with x_valid continuous. sym_ready pulses every 4th cycle; underflow_cnt = 0.
- Underflow: source drops valid for 2 symbol slots. The affected slots give x_out = 0 and underflow_cnt = 2. Data resumes in order with no duplicated symbol.
- Impulse, CLK_DIV = 2: start with mode = 1, then stop after 40 samples. Expect one x_out = 131071, then 39 zeros, then 32 flush zeros. done pulses once and busy drops the same cycle. x_valid appears every 2nd clock.
- Control corner cases:
  - start and stop together in IDLE enters RUN.
  - start during FLUSH is ignored.
  - stop in IDLE has no effect.
  - Reset asserted mid-RUN returns to IDLE with no done pulse.
- Saturation: force 65540 missed slots. underflow_cnt holds at 65535.
